ula_param: RTL
==============

ULA_PARAM -- requirements
Module: ula_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data path and register width in bits (legal 8..32).
REQ-002 SHALL have parameter NREG, default 16, number of registers (power of two, 4..32); AW = log2(NREG).
REQ-003 SHALL have one clock; reset is synchronous and active-high, port names clk and reset.
REQ-004 Ports, in order:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- opcode  in  4  operation select
- rd  in  AW  destination register
- rs  in  AW  first source register
- rt  in  AW  second source register
- imm  in  WIDTH  immediate operand
- busy  out  1  high while not IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; opcode unsupported
- result  out  WIDTH  last completed result, held until next done
- flags  out  4  {N,Z,C,V} of last completed op, held
- dbg_addr  in  AW  debug read select
- dbg_data  out  WIDTH  combinational register read for display

Function
REQ-005 SHALL hold NREG registers of WIDTH bits; register 0 reads as zero and ignores writes.
REQ-006 Opcodes: 0 ADD rs+rt; 1 SUB rs-rt; 2 SLT (rs<rt unsigned ? 1 : 0); 3 AND; 4 OR; 5 XOR rs,rt; 6 ANDI; 7 ORI; 8 XORI; 9 ADDI; A SUBI rs op imm; B MUL rs*rt low WIDTH bits; C SLL rs<<imm[4:0]; D SRL rs>>imm[4:0] logical; E,F illegal.
REQ-007 FSM states IDLE, EXEC, MUL, WB; reset state IDLE.
REQ-008 IDLE: start=1 at edge -> latch opcode, rd, rs/rt data, imm; go EXEC (or MUL if opcode B).
REQ-009 EXEC: compute result combinationally from latched operands, register it, go WB.
REQ-010 MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then WB.
REQ-011 WB: done=1 for exactly one cycle; register rd written at the edge leaving WB; return IDLE.
REQ-012 Latency start-edge to done-high: 2 cycles ALU/shift ops, WIDTH+1 cycles for MUL; busy high from edge after start until done cycle inclusive.
REQ-013 start while busy SHALL be ignored, not queued; start held high in IDLE after done begins a new op.
REQ-014 Operands SHALL be read at the start edge; a write to rs/rt completing at that same edge SHALL be bypassed (new value used).
REQ-015 ADD/ADDI: C = carry out, V = signed overflow; SUB/SUBI/SLT: C = borrow (rs<operand unsigned), V = signed overflow; logic/shift/MUL: C=0,V=0; Z = result==0, N = result[WIDTH-1] for all.
REQ-016 Shift amounts >= WIDTH SHALL yield 0.
REQ-017 Illegal opcode: done pulses with illegal=1, result=0, flags=0, no register write.
REQ-018 rd=0 SHALL complete normally (result/flags updated) with no register change.
REQ-019 dbg_data SHALL reflect the register value after any write, same-cycle combinational.

Reset
REQ-020 reset=1 at an edge SHALL: state IDLE, all registers 0, result 0, flags 0, done 0, illegal 0, busy 0.
REQ-021 reset during EXEC/MUL/WB SHALL abort the operation with no register write and no done pulse.
REQ-022 No initialisation mechanism other than reset; registers are loaded only via ops (e.g. ADDI from R0).

Verification
REQ-023 WIDTH=16: ADDI r1=R0+0x7FFF, ADDI r2=R0+1, ADD r3=r1+r2 -> result 0x8000, flags N=1,Z=0,C=0,V=1, done 2 cycles after start.
REQ-024 SUB r4=r2-r1 (1-0x7FFF) -> 0x8002, C=1,V=0; SLT r5=r2,r1 -> 1; SRL r1 by 20 -> 0, Z=1.
REQ-025 MUL r1(0x7FFF)*r1 -> 0x0001, done exactly 17 cycles after start, busy high throughout, start pulses mid-MUL ignored.
REQ-026 opcode F with rd=6 -> done with illegal=1, result 0, dbg_data for r6 unchanged; ADDI rd=0 -> dbg_data(0)=0.
REQ-027 Assert reset during MUL cycle 5 -> no done, target register unchanged-to-0, busy=0 next cycle; back-to-back ops with rs=previous rd use the written value.
REQ-028 Re-run REQ-023 with WIDTH=8, NREG=4: 0x7F+1 -> 0x80, V=1; MUL done 9 cycles after start.

Source files
------------

// File: rtl/ula_param.sv
// Multi-cycle ALU with a register file, a shift-add multiplier
// and N/Z/C/V flags.
module ula_param #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              opcode,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [$clog2(NREG)-1:0] rs,
  input  logic [$clog2(NREG)-1:0] rt,
  input  logic [WIDTH-1:0]        imm,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal,
  output logic [WIDTH-1:0]        result,
  output logic [3:0]              flags,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [WIDTH-1:0]        dbg_data
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int M  = WIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [5:0]    SH_LIM   = 6'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_MUL, S_WB
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [3:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_wen;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_illegal;

  logic             w_wen;
  logic [WIDTH-1:0] w_rs_data;
  logic [WIDTH-1:0] w_rt_data;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [4:0]       w_shamt;
  logic             w_sh_big;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [3:0]       w_flags;
  logic [WIDTH-1:0] w_acc_nx;

  // Register 0 is never written, so it always reads as zero.
  assign w_wen = (r_state == S_WB) && r_wen && (r_rd != '0);

  assign w_rs_data = (w_wen && r_rd == rs) ? r_result : r_regs[rs];
  assign w_rt_data = (w_wen && r_rd == rt) ? r_result : r_regs[rt];

  assign w_opb    = (r_op >= 4'h6 && r_op <= 4'hA) ? r_imm : r_b;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_opb};
  assign w_dif    = {1'b0, r_a} - {1'b0, w_opb};
  assign w_shamt  = r_imm[4:0];
  assign w_sh_big = {1'b0, w_shamt} >= SH_LIM;
  assign w_acc_nx = r_acc + (r_b[0] ? r_a : '0);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (r_op)
      4'h0, 4'h9: begin
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[M] == w_opb[M]) && (w_sum[M] != r_a[M]);
      end
      4'h1, 4'hA: begin
        w_res = w_dif[M:0];
        w_c   = w_dif[WIDTH];
        w_v   = (r_a[M] != w_opb[M]) && (w_dif[M] != r_a[M]);
      end
      4'h2: begin
        w_res = {{(WIDTH-1){1'b0}}, w_dif[WIDTH]};
        w_c   = w_dif[WIDTH];
        w_v   = (r_a[M] != w_opb[M]) && (w_dif[M] != r_a[M]);
      end
      4'h3, 4'h6: w_res = r_a & w_opb;
      4'h4, 4'h7: w_res = r_a | w_opb;
      4'h5, 4'h8: w_res = r_a ^ w_opb;
      4'hB:       w_res = '0;
      4'hC:       w_res = w_sh_big ? '0 : (r_a << w_shamt);
      4'hD:       w_res = w_sh_big ? '0 : (r_a >> w_shamt);
      default:    w_ill = 1'b1;
    endcase
    w_flags = w_ill ? 4'b0 : {w_res[M], w_res == '0, w_c, w_v};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_wen     <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= opcode;
            r_rd    <= rd;
            r_a     <= w_rs_data;
            r_b     <= w_rt_data;
            r_imm   <= imm;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= (opcode == 4'hB) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_result  <= w_res;
          r_flags   <= w_flags;
          r_illegal <= w_ill;
          r_wen     <= !w_ill;
          r_state   <= S_WB;
        end
        S_MUL: begin
          // One multiplier bit per cycle, LSB first.
          r_acc <= w_acc_nx;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result  <= w_acc_nx;
            r_flags   <= {w_acc_nx[M], w_acc_nx == '0, 2'b00};
            r_illegal <= 1'b0;
            r_wen     <= 1'b1;
            r_state   <= S_WB;
          end
        end
        default: begin
          if (w_wen) r_regs[r_rd] <= r_result;
          r_illegal <= 1'b0;
          r_wen     <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_WB);
  assign illegal  = r_illegal;
  assign result   = r_result;
  assign flags    = r_flags;
  assign dbg_data = r_regs[dbg_addr];

endmodule
